// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the aluop / alusrcb / pcsrc select values also used by aludec users.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPEEX  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BEQEX    = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ORIEX    = 4'd10,
    S_IMMWB    = 4'd11,
    S_JEX      = 4'd12
  } mc_state_t;

endpackage

// File: rtl/mc_controller_outdec.sv
// Combinational state-to-control decode for the multicycle controller.
// All controls are Moore except irwrite/pcwrite in FETCH, qualified by mem_ready.
module mc_controller_outdec
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_memwrite,
  output logic       o_iord,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_branch,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic       o_zeroext,
  output logic [1:0] o_pcsrc,
  output logic [1:0] o_aluop
);

  mc_state_t w_state;
  assign w_state = mc_state_t'(i_state);

  always_comb begin
    o_mem_req  = 1'b0;
    o_memwrite = 1'b0;
    o_iord     = 1'b0;
    o_irwrite  = 1'b0;
    o_pcwrite  = 1'b0;
    o_branch   = 1'b0;
    o_regwrite = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = SRCB_B;
    o_zeroext  = 1'b0;
    o_pcsrc    = PCSRC_ALU;
    o_aluop    = ALUOP_ADD;
    case (w_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        o_alusrcb = SRCB_FOUR;
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
      end
      // Branch target is computed here so BEQEX only needs the compare.
      S_DECODE: o_alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      S_MEMWB: begin
        o_regwrite = 1'b1;
        o_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_mem_req  = 1'b1;
        o_memwrite = 1'b1;
        o_iord     = 1'b1;
      end
      S_RTYPEEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_regwrite = 1'b1;
        o_regdst   = 1'b1;
      end
      S_BEQEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_SUB;
        o_branch  = 1'b1;
        o_pcsrc   = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      S_ORIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        o_aluop   = ALUOP_OR;
        o_zeroext = 1'b1;
      end
      S_IMMWB: o_regwrite = 1'b1;
      S_JEX: begin
        o_pcwrite = 1'b1;
        o_pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle MIPS core: state register, dispatch,
// retired-instruction counter and PC-enable gating.
module mc_controller
  import mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 memwrite,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 pcen,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroext,
  output logic [1:0]           pcsrc,
  output logic [1:0]           aluop,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           o_dbg_state
);

  // Memory handshake: mem_req is held with iord/memwrite stable until the
  // cycle mem_ready is high, which completes the access in that same cycle.

  mc_state_t              r_state;
  mc_state_t              w_next;
  logic                   w_retire;
  logic                   w_illegal;
  logic                   r_illegal_op;
  logic [INSTRET_W-1:0]   r_instret;

  logic w_mem_req, w_memwrite, w_irwrite, w_pcwrite, w_branch, w_regwrite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
      r_instret    <= '0;
    end else begin
      r_state      <= w_next;
      r_illegal_op <= w_illegal;
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_ORI:       w_next = S_ORIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_IMMWB;
      S_ORIEX:   w_next = S_IMMWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:   w_next = S_FETCH;
    endcase
  end

  mc_controller_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_mem_req   (w_mem_req),
    .o_memwrite  (w_memwrite),
    .o_iord      (iord),
    .o_irwrite   (w_irwrite),
    .o_pcwrite   (w_pcwrite),
    .o_branch    (w_branch),
    .o_regwrite  (w_regwrite),
    .o_regdst    (regdst),
    .o_memtoreg  (memtoreg),
    .o_alusrca   (alusrca),
    .o_alusrcb   (alusrcb),
    .o_zeroext   (zeroext),
    .o_pcsrc     (pcsrc),
    .o_aluop     (aluop)
  );

  // Side-effecting strobes are masked while reset is low, since the state
  // register already sits in FETCH during reset.
  assign mem_req     = w_mem_req & reset;
  assign memwrite    = w_memwrite & reset;
  assign irwrite     = w_irwrite & reset;
  assign regwrite    = w_regwrite & reset;
  assign pcen        = (w_pcwrite | (w_branch & zero)) & reset;
  assign illegal_op  = r_illegal_op;
  assign instret     = r_instret;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control vectors are
// queued from an instruction-level model and compared against the DUT.
module tb_mc_controller;
  import mc_pkg::*;

  logic clk, reset, zero, mem_ready;
  logic [5:0] op;

  logic mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
  logic alusrca, zeroext, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [31:0] instret;
  logic [3:0] dbg_state;

  logic w4_mem_req, w4_memwrite, w4_iord, w4_irwrite, w4_pcen, w4_regwrite;
  logic w4_regdst, w4_memtoreg, w4_alusrca, w4_zeroext, w4_illegal_op;
  logic [1:0] w4_alusrcb, w4_pcsrc, w4_aluop;
  logic [3:0] w4_instret, w4_dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_instret = '0;
  logic [20:0] exp_q[$];
  logic        rdy_q[$];

  mc_controller #(.INSTRET_W(32)) u_dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .pcsrc(pcsrc),
    .aluop(aluop), .illegal_op(illegal_op), .instret(instret),
    .o_dbg_state(dbg_state)
  );

  mc_controller #(.INSTRET_W(4)) u_w4 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(w4_mem_req), .memwrite(w4_memwrite), .iord(w4_iord),
    .irwrite(w4_irwrite), .pcen(w4_pcen), .regwrite(w4_regwrite),
    .regdst(w4_regdst), .memtoreg(w4_memtoreg), .alusrca(w4_alusrca),
    .alusrcb(w4_alusrcb), .zeroext(w4_zeroext), .pcsrc(w4_pcsrc),
    .aluop(w4_aluop), .illegal_op(w4_illegal_op), .instret(w4_instret),
    .o_dbg_state(w4_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control vector for one cycle:
  // {illegal, state, mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst,
  //  memtoreg, alusrca, alusrcb, zeroext, pcsrc, aluop}
  function automatic logic [20:0] model(mc_state_t s, logic rdy, logic z, logic ill);
    logic mreq, mw, ia, irw, pe, rw, rd, m2r, sa, ze;
    logic [1:0] sb, ps, ao;
    logic [3:0] st;
    mreq = 0; mw = 0; ia = 0; irw = 0; pe = 0; rw = 0; rd = 0; m2r = 0;
    sa = 0; ze = 0; sb = 2'b00; ps = 2'b00; ao = 2'b00;
    st = s;
    case (s)
      S_FETCH:   begin mreq = 1; sb = 2'b01; irw = rdy; pe = rdy; end
      S_DECODE:  sb = 2'b11;
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   begin mreq = 1; ia = 1; end
      S_MEMWB:   begin rw = 1; m2r = 1; end
      S_MEMWR:   begin mreq = 1; mw = 1; ia = 1; end
      S_RTYPEEX: begin sa = 1; ao = 2'b10; end
      S_RTYPEWB: begin rw = 1; rd = 1; end
      S_BEQEX:   begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_ORIEX:   begin sa = 1; sb = 2'b10; ao = 2'b11; ze = 1; end
      S_IMMWB:   rw = 1;
      S_JEX:     begin pe = 1; ps = 2'b10; end
      default: ;
    endcase
    return {ill, st, mreq, mw, ia, irw, pe, rw, rd, m2r, sa, sb, ze, ps, ao};
  endfunction

  task automatic push_step(mc_state_t s, logic rdy, logic z, logic ill);
    exp_q.push_back(model(s, rdy, z, ill));
    rdy_q.push_back(rdy);
  endtask

  // driver: replay queued cycles, then check retirement at the next edge
  task automatic drain(input logic [5:0] op_v, input logic z);
    logic [20:0] exp_v, got_v;
    logic rdy;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      rdy = rdy_q.pop_front();
      @(negedge clk);
      op = op_v; zero = z; mem_ready = rdy;
      #1;
      got_v = {illegal_op, dbg_state, mem_req, memwrite, iord, irwrite, pcen,
               regwrite, regdst, memtoreg, alusrca, alusrcb, zeroext, pcsrc, aluop};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL cycle op=%b got=%h exp=%h", op_v, got_v, exp_v);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (dbg_state !== 4'(S_FETCH) || instret !== exp_instret) begin
      bad++;
      $display("FAIL retire op=%b state=%0d instret=%0d exp_instret=%0d",
               op_v, dbg_state, instret, exp_instret);
    end
    total++;
    if (w4_instret !== exp_instret[3:0]) begin
      bad++;
      $display("FAIL instret_w4 got=%0d exp=%0d", w4_instret, exp_instret[3:0]);
    end
  endtask

  task automatic run_instr(input logic [5:0] op_v, input int fwait, input int mwait,
                           input logic z);
    for (int i = 0; i < fwait; i++) push_step(S_FETCH, 1'b0, z, 1'b0);
    push_step(S_FETCH, 1'b1, z, 1'b0);
    push_step(S_DECODE, 1'($urandom_range(0, 1)), z, 1'b0);
    case (op_v)
      OP_LW: begin
        push_step(S_MEMADR, 1'($urandom_range(0, 1)), z, 1'b0);
        for (int i = 0; i < mwait; i++) push_step(S_MEMRD, 1'b0, z, 1'b0);
        push_step(S_MEMRD, 1'b1, z, 1'b0);
        push_step(S_MEMWB, 1'($urandom_range(0, 1)), z, 1'b0);
      end
      OP_SW: begin
        push_step(S_MEMADR, 1'($urandom_range(0, 1)), z, 1'b0);
        for (int i = 0; i < mwait; i++) push_step(S_MEMWR, 1'b0, z, 1'b0);
        push_step(S_MEMWR, 1'b1, z, 1'b0);
      end
      OP_RTYPE: begin
        push_step(S_RTYPEEX, 1'($urandom_range(0, 1)), z, 1'b0);
        push_step(S_RTYPEWB, 1'($urandom_range(0, 1)), z, 1'b0);
      end
      OP_BEQ: push_step(S_BEQEX, 1'($urandom_range(0, 1)), z, 1'b0);
      OP_ADDI: begin
        push_step(S_ADDIEX, 1'($urandom_range(0, 1)), z, 1'b0);
        push_step(S_IMMWB, 1'($urandom_range(0, 1)), z, 1'b0);
      end
      OP_ORI: begin
        push_step(S_ORIEX, 1'($urandom_range(0, 1)), z, 1'b0);
        push_step(S_IMMWB, 1'($urandom_range(0, 1)), z, 1'b0);
      end
      OP_J: push_step(S_JEX, 1'($urandom_range(0, 1)), z, 1'b0);
      default: push_step(S_FETCH, 1'b0, z, 1'b1);
    endcase
    if (op_v inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ORI, OP_J})
      exp_instret = exp_instret + 32'd1;
    drain(op_v, z);
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({mem_req, irwrite, pcen, regwrite, memwrite} !== 5'b0 ||
        dbg_state !== 4'(S_FETCH) || instret !== 32'd0 || illegal_op !== 1'b0 ||
        w4_instret !== 4'd0) begin
      bad++;
      $display("FAIL %s strobes=%b state=%0d instret=%0d illegal=%b", name,
               {mem_req, irwrite, pcen, regwrite, memwrite}, dbg_state, instret,
               illegal_op);
    end
  endtask

  task automatic release_reset(input string name);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    exp_instret = '0;
    #1;
    total++;
    if (mem_req !== 1'b1 || dbg_state !== 4'(S_FETCH) || instret !== 32'd0) begin
      bad++;
      $display("FAIL %s first_fetch mem_req=%b state=%0d instret=%0d", name,
               mem_req, dbg_state, instret);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; op = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    release_reset("reset_release");
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_instr(OP_LW, 0, 0, 1'b0);
    @(negedge clk); op = OP_LW; mem_ready = 1'b1;   // FETCH
    @(negedge clk); mem_ready = 1'b0;               // DECODE
    @(negedge clk);                                 // MEMADR
    @(negedge clk); #1;                             // MEMRD, waiting
    total++;
    if (dbg_state !== 4'(S_MEMRD) || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_memrd state=%0d mem_req=%b", dbg_state, mem_req);
    end
    #1 reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_held");
    release_reset("reset_mid_release");
  endtask

  task automatic test_sw();
    run_instr(OP_SW, 0, 3, 1'b0);
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
  endtask

  task automatic test_ori_illegal();
    run_instr(OP_ORI, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_ADDI, 2, 0, 1'b1);
    run_instr(OP_RTYPE, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    ops[4] = OP_ADDI; ops[5] = OP_ORI; ops[6] = OP_J; ops[7] = 6'b010101;
    for (int i = 0; i < 20; i++)
      run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_wrap();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("wrap_reset");
    release_reset("wrap_release");
    for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0, 1'b0);
    total++;
    if (w4_instret !== 4'd0 || instret !== 32'd16) begin
      bad++;
      $display("FAIL wrap w4_instret=%0d instret=%0d need 0 and 16",
               w4_instret, instret);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_reset_mid();
    test_sw();
    test_beq();
    test_ori_illegal();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
